latch_bank_arbiter: RTL and testbench
=====================================

Name: latch_bank_arbiter

Overview:
Write controller that shares one bank of DEPTH level-sensitive D latches (each W bits) between NREQ requesters. Round-robin arbitration picks one write at a time. Each write follows a fixed sequence: data setup, then a transparent-enable window, then data hold. Sits between the register-write clients and the latch bank; it drives every latch's d and ctl inputs.

Parameters:
NREQ, 4, number of requesters (≥2)
DEPTH, 8, number of latches in the bank
AW, 3, address width; latches 0..DEPTH-1 addressable
W, 8, data width per latch
OPEN_CYC, 2, cycles latch_en is held high (≥1)
HOLD_CYC, 1, cycles latch_d is held stable after latch_en falls (≥1)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
req  input  NREQ  per-requester write request, level
wr_addr  input  NREQ*AW  requester i address at [i*AW +: AW]
wr_data  input  NREQ*W  requester i data at [i*W +: W]
gnt  output  NREQ  one-cycle one-hot pulse: request accepted
done  output  NREQ  one-cycle one-hot pulse: write complete
err  output  1  one-cycle pulse with done when address ≥ DEPTH
latch_d  output  W  shared data to all latch d inputs
latch_en  output  DEPTH  one-hot latch ctl enables
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at edge): state=IDLE, gnt=0, done=0, err=0, latch_en=0, latch_d=0, rr_ptr=0. Reset mid-transaction aborts it; latch_en drops at that same edge and no done is issued.
- FSM states: IDLE, SETUP, OPEN, HOLD, DONE. All outputs are registered.
- IDLE: if any req is high, select the first requester at or above rr_ptr, wrapping modulo NREQ. Capture its addr and data into owner/addr/data registers, pulse gnt[owner], set latch_d=data, then go to SETUP. With no req, stay in IDLE; latch_d keeps its last value.
- SETUP: 1 cycle. latch_en=0, latch_d stable. Next state is OPEN.
- OPEN: OPEN_CYC cycles. latch_en[addr]=1, all other enable bits 0. If addr ≥ DEPTH, latch_en stays all zero and the addr_bad flag is set. Next state is HOLD.
- HOLD: HOLD_CYC cycles. latch_en=0, latch_d unchanged. Next state is DONE.
- DONE: 1 cycle. done[owner]=1, err=addr_bad. rr_ptr=(owner+1) mod NREQ. Next state is IDLE.
- Latency: req sampled at edge E0 gives gnt in cycle 1, latch_en in cycles 2..1+OPEN_CYC, and done in cycle 2+OPEN_CYC+HOLD_CYC. Bank occupancy is 3+OPEN_CYC+HOLD_CYC cycles per write.
- Defaults: gnt in cycle 1, en in cycles 2–3, hold in cycle 4, done in cycle 5, earliest next gnt in cycle 7.
- Requester protocol: hold req with stable addr/data until gnt. After gnt, inputs are don't-care because values are captured. Deassert req in the cycle after done, or another write is queued.
- A req drop after gnt does not abort the transaction.
- Only one enable bit may ever be high. latch_d must never change while any latch_en bit is high or during HOLD.
- Simultaneous requests: exactly one gnt. The losers wait and are served in rotation order starting from rr_ptr.

Test Plan:
- Single write: req[2]=1, addr=5, data=8'hA5 → gnt[2] in cycle 1; latch_en=8'b0010_0000 in cycles 2–3; latch_d=A5 in cycles 1–4; done[2] in cycle 5; err=0; busy=1 in cycles 1–5.
- Contention: req=4'b1111 held, each requester drops req after its done → grant order 0,1,2,3; gnts spaced 6 cycles apart; done for each in the same order; latch_en never has more than one bit set.
- Round-robin fairness: req[0] and req[3] both held continuously → grants alternate 0,3,0,3; neither requester is starved.
- Bad address: req[1], addr=7 with DEPTH=6 → gnt[1]; latch_en stays 0 throughout; done[1] and err=1 in the same cycle.
- Reset mid-OPEN: assert rst in cycle 2 → latch_en=0, busy=0, no done; next req[3] after reset is granted first (rr_ptr=0, only req[3] high).
- Data stability: change wr_data every cycle after gnt → latch_d stays equal to the captured value through HOLD (checked by assertion).

Source files
------------

// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter
// Round-robin write controller sharing one bank of DEPTH level-sensitive
// latches between NREQ requesters. Each write runs a fixed sequence:
// setup (latch_d valid, enables low), OPEN_CYC cycles of one-hot latch_en,
// HOLD_CYC cycles with latch_d still stable, then a done pulse.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   req      in   [NREQ]     per-requester write request (level)
//   wr_addr  in   [NREQ*AW]  requester i address at [i*AW +: AW]
//   wr_data  in   [NREQ*W]   requester i data at [i*W +: W]
//   gnt      out  [NREQ]     one-hot pulse, request accepted
//   done     out  [NREQ]     one-hot pulse, write complete
//   err      out             pulse with done when address >= DEPTH
//   latch_d  out  [W]        shared latch data
//   latch_en out  [DEPTH]    one-hot latch enables
//   busy     out             high whenever not idle
module latch_bank_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = 3,
  parameter int unsigned W        = 8,
  parameter int unsigned OPEN_CYC = 2,
  parameter int unsigned HOLD_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   wr_addr,
  input  logic [NREQ*W-1:0]    wr_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [W-1:0]         latch_d,
  output logic [DEPTH-1:0]     latch_en,
  output logic                 busy
);

  localparam int unsigned OW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CMAX = (OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_OPEN  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [OW-1:0]   r_owner;
  logic [AW-1:0]   r_addr;
  logic            r_bad;
  logic [OW-1:0]   r_ptr, w_ptr_nxt;

  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic [NREQ-1:0]  r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic [W-1:0]     r_d, w_d_nxt;
  logic [DEPTH-1:0] r_en, w_en_nxt;
  logic             r_busy;
  logic             w_cap;

  logic             w_pick_vld;
  logic [OW-1:0]    w_pick;
  logic [OW:0]      w_sum;
  logic [AW-1:0]    w_pick_addr;
  logic [W-1:0]     w_pick_data;
  logic             w_pick_bad;
  logic [DEPTH-1:0] w_en_vec;

  // Round-robin pick: first requester at or above r_ptr, wrapping. Iterate
  // from the far end so the nearest candidate overwrites the others.
  always_comb begin : arb
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_sum      = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_ptr} + (OW+1)'(i);
      if (w_sum >= (OW+1)'(NREQ)) w_sum = w_sum - (OW+1)'(NREQ);
      if (req[w_sum[OW-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_sum[OW-1:0];
      end
    end
  end

  // Select the picked requester's address and data.
  always_comb begin : sel
    w_pick_addr = '0;
    w_pick_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_pick == OW'(i)) begin
        w_pick_addr = wr_addr[i*AW +: AW];
        w_pick_data = wr_data[i*W +: W];
      end
    end
  end

  assign w_pick_bad = (32'(w_pick_addr) >= 32'(DEPTH));
  // Out-of-range addresses never raise an enable bit.
  assign w_en_vec   = r_bad ? '0 : (DEPTH'(1) << r_addr);

  // Next state and next registered outputs.
  always_comb begin : fsm_nxt
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = '0;
    w_done_nxt  = '0;
    w_err_nxt   = 1'b0;
    w_en_nxt    = '0;
    w_d_nxt     = r_d;
    w_cap       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = S_SETUP;
          w_cap       = 1'b1;
          w_gnt_nxt   = NREQ'(1) << w_pick;
          w_d_nxt     = w_pick_data;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_OPEN;
        w_cnt_nxt   = '0;
        w_en_nxt    = w_en_vec;
      end
      S_OPEN: begin
        if (r_cnt == CW'(OPEN_CYC - 1)) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          w_en_nxt  = w_en_vec;
        end
      end
      S_HOLD: begin
        if (r_cnt == CW'(HOLD_CYC - 1)) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
          w_done_nxt  = NREQ'(1) << r_owner;
          w_err_nxt   = r_bad;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = (r_owner == OW'(NREQ - 1)) ? '0 : (r_owner + OW'(1));
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, transaction capture and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_addr  <= '0;
      r_bad   <= 1'b0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_d     <= '0;
      r_en    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_cap) begin
        r_owner <= w_pick;
        r_addr  <= w_pick_addr;
        r_bad   <= w_pick_bad;
      end
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_d     <= w_d_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign err      = r_err;
  assign latch_d  = r_d;
  assign latch_en = r_en;
  assign busy     = r_busy;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Testbench for latch_bank_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a transaction-schedule model.
module tb_latch_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int DEPTH = 6;
  localparam int AW    = 3;
  localparam int W     = 8;
  localparam int OPENC = 2;
  localparam int HOLDC = 1;
  localparam int LAST  = 2 + OPENC + HOLDC;  // cycle index of done after grant

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   wr_addr;
  logic [NREQ*W-1:0]    wr_data;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic                 err;
  logic [W-1:0]         latch_d;
  logic [DEPTH-1:0]     latch_en;
  logic                 busy;

  latch_bank_arbiter #(
    .NREQ(NREQ), .DEPTH(DEPTH), .AW(AW), .W(W),
    .OPEN_CYC(OPENC), .HOLD_CYC(HOLDC)
  ) u_dut (
    .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(gnt), .done(done), .err(err), .latch_d(latch_d),
    .latch_en(latch_en), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one transaction occupies cycles k=1..LAST after grant.
  bit       m_active;
  int       m_k;
  int       m_owner;
  int       m_addr;
  int       m_ptr;
  logic [7:0] m_d;

  logic [NREQ-1:0]  e_gnt, e_done;
  logic [DEPTH-1:0] e_en;
  logic             e_err, e_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_active = 0; m_ptr = 0; m_d = '0; m_k = 0;
    end else if (m_active) begin
      if (m_k == LAST) begin
        m_active = 0;
        m_ptr = (m_owner + 1) % NREQ;
      end else begin
        m_k++;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        int idx;
        idx = (m_ptr + i) % NREQ;
        if (!m_active && req[idx]) begin
          m_active = 1;
          m_k      = 1;
          m_owner  = idx;
          m_addr   = int'(wr_addr[idx*AW +: AW]);
          m_d      = wr_data[idx*W +: W];
        end
      end
    end
    e_gnt  = (m_active && m_k == 1) ? NREQ'(1) << m_owner : '0;
    e_en   = (m_active && m_k >= 2 && m_k <= 1 + OPENC && m_addr < DEPTH) ? DEPTH'(1) << m_addr : '0;
    e_done = (m_active && m_k == LAST) ? NREQ'(1) << m_owner : '0;
    e_err  = m_active && m_k == LAST && m_addr >= DEPTH;
    e_busy = m_active;
  endtask

  task automatic check_all();
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("latch_en", 32'(latch_en), 32'(e_en));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("latch_d", 32'(latch_d), 32'(m_d));
    chk("en_onehot0", 32'($onehot0(latch_en)), 32'(1));
  endtask

  // One clock: inputs already driven; model follows the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_port(input int i, input int a, input logic [7:0] d);
    wr_addr[i*AW +: AW] = AW'(a);
    wr_data[i*W +: W]   = d;
  endtask

  int          gq[$];
  int          gc[$];
  int          cyc;
  logic [3:0]  exp_fair [4];
  logic [3:0]  exp_cont [4];

  initial begin
    rst = 1'b1; req = '0; wr_addr = '0; wr_data = '0;
    m_active = 0; m_ptr = 0; m_d = '0; m_k = 0; m_owner = 0; m_addr = 0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Single write: requester 2, address 5, data A5.
    req = 4'b0100; set_port(2, 5, 8'hA5);
    cycle();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_d_c1", 32'(latch_d), 32'hA5);
    req = '0; set_port(2, 1, 8'h11);
    cycle();
    chk("single_en_c2", 32'(latch_en), 32'b10_0000);
    cycle();
    chk("single_en_c3", 32'(latch_en), 32'b10_0000);
    cycle();
    chk("single_hold_en", 32'(latch_en), 32'h0);
    chk("single_hold_d", 32'(latch_d), 32'hA5);
    cycle();
    chk("single_done", 32'(done), 32'h4);
    chk("single_err", 32'(err), 32'h0);
    cycle();
    chk("single_idle_busy", 32'(busy), 32'h0);

    // Bad address: requester 1, address 7 (>= DEPTH).
    req = 4'b0010; set_port(1, 7, 8'h3C);
    cycle();
    chk("bad_gnt", 32'(gnt), 32'h2);
    req = '0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("bad_en_zero", 32'(latch_en), 32'h0);
    end
    cycle();
    chk("bad_done", 32'(done), 32'h2);
    chk("bad_err", 32'(err), 32'h1);
    cycle();

    // Reset in the first OPEN cycle aborts; requester 3 is served next.
    req = 4'b0001; set_port(0, 2, 8'h5A);
    cycle();
    req = '0;
    cycle();
    chk("abort_en_before", 32'(latch_en), 32'b00_0100);
    rst = 1'b1;
    cycle();
    chk("abort_en", 32'(latch_en), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("abort_no_done", 32'(done), 32'h0);
    end
    req = 4'b1000; set_port(3, 4, 8'hC3);
    cycle();
    chk("after_rst_gnt", 32'(gnt), 32'h8);
    req = '0;
    for (int c = 0; c < 6; c++) cycle();

    // Contention: all four request, each drops right after its done.
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_port(i, i + 1, 8'(8'h10 * (i + 1)));
    req = 4'hF;
    gq.delete(); gc.delete();
    for (cyc = 1; cyc <= 26; cyc++) begin
      cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin gq.push_back(i); gc.push_back(cyc); end
        if (e_done[i]) req[i] = 1'b0;
      end
    end
    exp_cont[0] = 4'd0; exp_cont[1] = 4'd1; exp_cont[2] = 4'd2; exp_cont[3] = 4'd3;
    chk("cont_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      chk("cont_order", 32'(gq[i]), 32'(exp_cont[i]));
      if (i > 0) chk("cont_spacing", 32'(gc[i] - gc[i-1]), 32'd6);
    end

    // Fairness: requesters 0 and 3 held continuously alternate.
    rst = 1'b1; cycle(); rst = 1'b0;
    req = 4'b1001;
    gq.delete();
    for (int c = 0; c < 24; c++) begin
      cycle();
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gq.push_back(i);
    end
    req = '0;
    exp_fair[0] = 4'd0; exp_fair[1] = 4'd3; exp_fair[2] = 4'd0; exp_fair[3] = 4'd3;
    chk("fair_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      chk("fair_order", 32'(gq[i]), 32'(exp_fair[i]));
    for (int c = 0; c < 6; c++) cycle();

    // Random traffic: data and addresses change every cycle, occasional reset.
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 59) == 0);
      req     = NREQ'($urandom);
      wr_addr = NREQ*AW'($urandom);
      wr_data = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
